// File: rtl/mod_counter_pkg.sv
// Shared definitions for the up/down loadable modulo counter.
// Contents:
//   DIR_UP / DIR_DOWN   - encodings of the up_dn input
//   MODE_WRAP / MODE_SAT - encodings of the sat_mode input
//   clamp_to_max        - min(value, max) on zero-extended 32-bit operands;
//                         callers size-cast the result back to their width.
package mod_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Operands are widened to 32 bits so one function serves every counter width.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-state logic for one counter step.
// Ports:
//   q           in   current count
//   clear, load in   higher-priority controls; they only suppress term_event
//   en_in       in   count enable
//   up_dn       in   1 = up, 0 = down
//   sat_mode    in   1 = saturate, 0 = wrap
//   max_value   in   terminal value, range is 0..max_value
//   next_q      out  count after an enabled step
//   at_terminal out  up: q >= max_value, down: q == 0
//   term_event  out  enabled step at the terminal with no clear/load
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q,
  input  logic         clear,
  input  logic         load,
  input  logic         en_in,
  input  logic         up_dn,
  input  logic         sat_mode,
  input  logic [N-1:0] max_value,
  output logic [N-1:0] next_q,
  output logic         at_terminal,
  output logic         term_event
);

  // Up path compares with >= so an out-of-range q (max_value lowered under a
  // running count) is treated as terminal and pulled back into range.
  // Down path clamps an out-of-range q to max_value without flagging an event.
  always_comb begin
    next_q      = q;
    at_terminal = 1'b0;
    if (up_dn == DIR_UP) begin
      at_terminal = (q >= max_value);
      if (!at_terminal)
        next_q = q + 1'b1;
      else if (sat_mode == MODE_SAT)
        next_q = max_value;
      else
        next_q = '0;
    end else begin
      at_terminal = (q == '0);
      if (q > max_value)
        next_q = N'(clamp_to_max(32'(q), 32'(max_value)));
      else if (!at_terminal)
        next_q = q - 1'b1;
      else if (sat_mode == MODE_SAT)
        next_q = '0;
      else
        next_q = max_value;
    end
    term_event = en_in & at_terminal & ~clear & ~load;
  end

endmodule

// File: rtl/mod_counter_updn_load.sv
// Up/down modulo counter with run-time terminal value, wrap/saturate mode,
// synchronous clear, parallel load, cascade output and event flags.
// Ports:
//   clk, reset_n  in   clock, asynchronous active-low reset
//   clear         in   synchronous clear of q and both event flags
//   load          in   load min(load_value, max_value)
//   load_value    in   value to load
//   en_in         in   count enable (previous stage's tc_out when cascading)
//   up_dn         in   direction, 1 = up
//   sat_mode      in   1 = saturate at terminal, 0 = wrap
//   max_value     in   terminal value
//   q             out  registered count
//   tc_out        out  en_in & at_terminal, combinational
//   event_pulse   out  one-cycle pulse the cycle after a terminal event
//   event_sticky  out  set by any terminal event, cleared by clear/reset
module mod_counter_updn_load
  import mod_counter_pkg::*;
#(
  parameter int N           = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         en_in,
  input  logic         up_dn,
  input  logic         sat_mode,
  input  logic [N-1:0] max_value,
  output logic [N-1:0] q,
  output logic         tc_out,
  output logic         event_pulse,
  output logic         event_sticky
);

  logic [N-1:0] next_q;
  logic [N-1:0] load_q;
  logic         at_terminal;
  logic         term_event;

  mod_counter_next #(.N(N)) u_next (
    .q           (q),
    .clear       (clear),
    .load        (load),
    .en_in       (en_in),
    .up_dn       (up_dn),
    .sat_mode    (sat_mode),
    .max_value   (max_value),
    .next_q      (next_q),
    .at_terminal (at_terminal),
    .term_event  (term_event)
  );

  // Loads never place q outside the counting range.
  assign load_q = N'(clamp_to_max(32'(load_value), 32'(max_value)));

  assign tc_out = en_in & at_terminal;

  // Priority: clear, then load, then an enabled step, otherwise hold.
  // term_event already excludes clear/load, so it drives the pulse directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q            <= N'(RESET_VALUE);
      event_pulse  <= 1'b0;
      event_sticky <= 1'b0;
    end else if (clear) begin
      q            <= '0;
      event_pulse  <= 1'b0;
      event_sticky <= 1'b0;
    end else if (load) begin
      q           <= load_q;
      event_pulse <= 1'b0;
    end else if (en_in) begin
      q           <= next_q;
      event_pulse <= term_event;
      if (term_event)
        event_sticky <= 1'b1;
    end else begin
      event_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter_updn_load.sv
// Self-checking bench for mod_counter_updn_load: directed scenarios plus
// randomized traffic, all compared against a behavioural model of the count.
module tb_mod_counter_updn_load;

  logic       clk;
  logic       reset_n;
  logic       clear, load, en_in, up_dn, sat_mode;
  logic [3:0] load_value, max_value;
  logic [3:0] q;
  logic       tc_out, event_pulse, event_sticky;

  // Two-digit decimal cascade
  logic       casc_en;
  logic       zero_bit;
  logic [3:0] zero_val, nine_val;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_pulse, hi_pulse, lo_sticky, hi_sticky;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state
  int  modelQ;
  bit  modelPulse;
  bit  modelSticky;

  mod_counter_updn_load #(.N(4), .RESET_VALUE(3)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .en_in(en_in), .up_dn(up_dn),
    .sat_mode(sat_mode), .max_value(max_value), .q(q), .tc_out(tc_out),
    .event_pulse(event_pulse), .event_sticky(event_sticky)
  );

  mod_counter_updn_load #(.N(4), .RESET_VALUE(0)) lo_stage (
    .clk(clk), .reset_n(reset_n), .clear(zero_bit), .load(zero_bit),
    .load_value(zero_val), .en_in(casc_en), .up_dn(1'b1),
    .sat_mode(zero_bit), .max_value(nine_val), .q(lo_q), .tc_out(lo_tc),
    .event_pulse(lo_pulse), .event_sticky(lo_sticky)
  );

  mod_counter_updn_load #(.N(4), .RESET_VALUE(0)) hi_stage (
    .clk(clk), .reset_n(reset_n), .clear(zero_bit), .load(zero_bit),
    .load_value(zero_val), .en_in(lo_tc), .up_dn(1'b1),
    .sat_mode(zero_bit), .max_value(nine_val), .q(hi_q), .tc_out(hi_tc),
    .event_pulse(hi_pulse), .event_sticky(hi_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check tc_out combinationally,
  // advance the model on the rising edge, then check the registered outputs.
  task automatic applyStimulus(input bit c, input bit l, input int lv, input bit e,
                               input bit u, input bit s, input int mx);
    bit term;
    int lvc;
    @(negedge clk);
    clear = c; load = l; load_value = 4'(lv); en_in = e;
    up_dn = u; sat_mode = s; max_value = 4'(mx);
    #1;
    term = u ? (modelQ >= mx) : (modelQ == 0);
    checkOutput("tc_out", int'(tc_out), int'(e && term));
    @(posedge clk);
    if (c) begin
      modelQ = 0; modelPulse = 0; modelSticky = 0;
    end else if (l) begin
      lvc = (lv > mx) ? mx : lv;
      modelQ = lvc; modelPulse = 0;
    end else if (e) begin
      modelPulse = 0;
      if (u) begin
        if (modelQ < mx) modelQ = modelQ + 1;
        else begin
          modelQ = s ? mx : 0; modelPulse = 1; modelSticky = 1;
        end
      end else begin
        if (modelQ > mx) modelQ = mx;
        else if (modelQ > 0) modelQ = modelQ - 1;
        else begin
          modelQ = s ? 0 : mx; modelPulse = 1; modelSticky = 1;
        end
      end
    end else begin
      modelPulse = 0;
    end
    #1;
    checkOutput("q", int'(q), modelQ);
    checkOutput("event_pulse", int'(event_pulse), int'(modelPulse));
    checkOutput("event_sticky", int'(event_sticky), int'(modelSticky));
  endtask

  initial begin
    int hiPulses;
    int mx;
    bit c, l, e, u, s;
    zero_bit = 1'b0; zero_val = 4'd0; nine_val = 4'd9; casc_en = 1'b0;
    clear = 0; load = 0; load_value = 0; en_in = 0; up_dn = 1; sat_mode = 0;
    max_value = 4'd15;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_q", int'(q), 3);
    checkOutput("reset_pulse", int'(event_pulse), 0);
    checkOutput("reset_sticky", int'(event_sticky), 0);
    modelQ = 3; modelPulse = 0; modelSticky = 0;
    @(negedge clk) reset_n = 1'b1;

    // Cascade: 100 enabled cycles from 00 end at 00 with one high-digit event
    hiPulses = 0;
    @(negedge clk) casc_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      checkOutput("cascade_value", int'(hi_q) * 10 + int'(lo_q), i % 100);
      if (hi_pulse) hiPulses++;
      @(negedge clk);
    end
    casc_en = 1'b0;
    checkOutput("cascade_hi_pulses", hiPulses, 1);

    // Count up from reset value to 7, then reset asynchronously between edges
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1, 0, 15);
    checkOutput("count_to_7", int'(q), 7);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_q", int'(q), 3);
    checkOutput("async_reset_sticky", int'(event_sticky), 0);
    modelQ = 3; modelPulse = 0; modelSticky = 0;
    @(negedge clk) reset_n = 1'b1;

    // Up wrap, max 9, from 0
    applyStimulus(1, 0, 0, 0, 1, 0, 9);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 1, 0, 9);

    // Down saturate from load 5
    applyStimulus(0, 1, 5, 0, 0, 1, 5);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 0, 1, 5);

    // Clear drops the sticky flag
    applyStimulus(1, 0, 0, 1, 0, 1, 5);
    checkOutput("clear_sticky", int'(event_sticky), 0);

    // Load clamp and priority
    applyStimulus(0, 1, 12, 0, 1, 0, 6);
    checkOutput("load_clamp", int'(q), 6);
    applyStimulus(1, 1, 3, 1, 1, 0, 6);
    checkOutput("clear_over_load", int'(q), 0);
    applyStimulus(0, 1, 2, 1, 1, 0, 6);
    checkOutput("load_over_en", int'(q), 2);

    // max_value lowered under q = 12
    applyStimulus(0, 1, 12, 0, 1, 0, 15);
    applyStimulus(0, 0, 0, 1, 1, 0, 4);
    checkOutput("lowered_up_wrap", int'(q), 0);
    applyStimulus(0, 1, 12, 0, 1, 0, 15);
    applyStimulus(0, 0, 0, 1, 1, 1, 4);
    checkOutput("lowered_up_sat", int'(q), 4);
    applyStimulus(0, 1, 12, 0, 1, 0, 15);
    applyStimulus(0, 0, 0, 1, 0, 0, 4);
    checkOutput("lowered_down", int'(q), 4);
    checkOutput("lowered_down_pulse", int'(event_pulse), 0);

    // Randomized traffic
    mx = 9;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(3))
          0: mx = 0;
          1: mx = 15;
          default: mx = int'($urandom_range(15));
        endcase
      end
      c = ($urandom_range(19) == 0);
      l = ($urandom_range(7) == 0);
      e = ($urandom_range(3) != 0);
      u = 1'($urandom_range(1));
      s = 1'($urandom_range(1));
      applyStimulus(c, l, int'($urandom_range(15)), e, u, s, mx);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mod_counter_updn_load.md
Name: mod_counter_updn_load

Overview:
- Parametrised successor to the team's fixed up-counting modulo counter.
- Adds up/down direction, a run-time terminal value, wrap or saturate mode, synchronous clear and parallel load.
- Adds a cascade-ready terminal-count output and a sticky event flag.
- Used as the general-purpose timer/index counter in datapath and control blocks; instances chain through en_in/tc_out.

Parameters:
- N, 4, counter width in bits.
- RESET_VALUE, 0, value of q after reset; must be less than 2^N.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear; q<=0, sticky cleared.
- load  input  1  synchronous parallel load of load_value.
- load_value  input  N  value to load.
- en_in  input  1  count enable; tie to previous stage's tc_out when cascading.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- sat_mode  input  1  terminal behaviour: 1 = saturate/hold, 0 = wrap.
- max_value  input  N  terminal value; counting range is 0..max_value.
- q  output  N  registered count.
- tc_out  output  1  combinational terminal count = en_in & at_terminal.
- event_pulse  output  1  registered one-cycle pulse, asserted the cycle after a terminal event.
- event_sticky  output  1  registered flag set by any terminal event; cleared only by clear or reset.

Behaviour:
- One clock; reset is asynchronous and active-low: clk and reset_n.
- Reset values: q=RESET_VALUE, event_pulse=0, event_sticky=0. Reset asserted mid-count takes effect immediately, independent of clk.
- at_terminal: up_dn=1 -> (q >= max_value); up_dn=0 -> (q == 0).
- Terminal event: en_in=1 and at_terminal=1, and neither clear nor load is active.
- Per-edge priority, highest first:
  - clear: q<=0, event_sticky<=0, event_pulse<=0.
  - load: q<=min(load_value, max_value), event_pulse<=0, event_sticky unchanged.
  - en_in=1: count step per the rules below.
  - otherwise: hold q, event_pulse<=0.
- Up, not terminal: q<=q+1.
- Up, terminal:
  - wrap mode: q<=0.
  - saturate mode: q<=max_value. This also pulls an out-of-range q (q > max_value after max_value is lowered) down to max_value.
- Down, q > max_value: q<=max_value. Not a terminal event.
- Down, 0 < q <= max_value: q<=q-1.
- Down, q == 0:
  - wrap mode: q<=max_value.
  - saturate mode: q holds at 0.
- On a terminal event: event_pulse<=1 for exactly one cycle, event_sticky<=1. In saturate mode, holding at the terminal with en_in=1 re-fires event_pulse on every cycle.
- max_value=0: q stays 0; tc_out=en_in; every enabled cycle is a terminal event.
- Width rules: all arithmetic is N-bit. q+1 is only taken when q<max_value, so it never overflows. max_value=2^N-1 gives a full binary counter.
- Latency: q and event_* update one cycle after their inputs. tc_out has zero latency.
- Cascading: stage k's en_in = stage k-1's tc_out, which forms a multi-digit counter (e.g. BCD with max_value=9).
- Direction or mode changes take effect on the next edge; no state is retained across the change.

Decomposition:
- Shared package mod_counter_pkg:
  - constants DIR_UP=1'b1, DIR_DOWN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - a function clamp_to_max(value, max) used by the load path and the down path.
- Sub-module mod_counter_next: purely combinational. Computes next_q, at_terminal and term_event from q and the controls.
- Top level holds the q register, the event registers and the priority mux.

Test Plan:
- Reset/clear: N=4, RESET_VALUE=3; deassert reset_n -> q=3, event_*=0. Count to 7, assert reset_n=0 between edges -> q=3 immediately. Later pulse clear -> q=0, event_sticky=0.
- Up wrap: max_value=9, sat_mode=0, up_dn=1, en_in=1 from q=0 -> q sequence 0..9,0. tc_out=1 only while q=9. event_pulse high one cycle at q=0. event_sticky stays 1.
- Down saturate: max_value=5, sat_mode=1, up_dn=0, load 5 -> q sequence 5,4,3,2,1,0,0,0. event_pulse=1 on each cycle after the first arrival at 0.
- Load clamp/priority: max_value=6, load_value=12 -> q=6. Assert clear+load+en_in together -> q=0. Assert load+en_in with load_value=2 -> q=2, no increment.
- max_value lowered: q=12, max_value changed to 4:
  - up, wrap mode -> q=0, event fires.
  - up, saturate mode -> q=4, event fires.
  - down -> q=4, no event.
- Cascade: two instances, max_value=9 each, low stage's tc_out -> high stage's en_in. Run 100 cycles from 00 -> digits {9,9} then {0,0}. High stage event_pulse fires once.
